// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scan driver.
// A prescaler/digit counter walks the digits; display data is double-buffered
// so a frame is always drawn from one consistent snapshot. Per-digit decode
// lives in seg_digit_lane, one instance per digit; the active lane is muxed
// out and registered with the configured output polarity.

// Per-digit decode: hex font lookup plus blanking (active-high outputs).
module seg_digit_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp_o
);

  logic [6:0] font;

  // Hex font, bit0 = top segment through bit6 = middle segment.
  always_comb begin
    font = 7'h00;
    case (nib)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      4'hF: font = 7'h71;
      default: font = 7'h00;
    endcase
  end

  assign seg  = blank ? 7'h00 : font;
  assign dp_o = blank ? 1'b0  : dp;

endmodule

// Top-level scan driver.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_DIG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int DW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic          SEG_INV = (ACTIVE_LOW_SEG != 0);
  localparam logic          DIG_INV = (ACTIVE_LOW_DIG != 0);

  // scan position
  logic [PW-1:0] p;
  logic [DW-1:0] d;
  logic          fb;

  // blink timing
  logic [FW-1:0] fcnt;
  logic          phase;

  // double-buffered display data
  logic [NUM_DIGITS-1:0][3:0] disp_val, pend_val;
  logic [NUM_DIGITS-1:0]      disp_dp, pend_dp;
  logic [NUM_DIGITS-1:0]      disp_blink, pend_blink;
  logic                       pend_vld;

  // lane outputs
  logic [NUM_DIGITS-1:0]      lane_blank;
  logic [NUM_DIGITS-1:0][6:0] lane_seg;
  logic [NUM_DIGITS-1:0]      lane_dp;

  // next-cycle output values (active-high)
  logic [6:0]            nxt_seg;
  logic                  nxt_dp;
  logic [NUM_DIGITS-1:0] nxt_sel;
  logic                  zf;

  // Last cycle of the last digit slot: the only point display data may change.
  assign fb = (p == P_LAST) && (d == D_LAST);

  // Prescaler and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
      d <= '0;
    end else if (p == P_LAST) begin
      p <= '0;
      d <= (d == D_LAST) ? '0 : d + DW'(1);
    end else begin
      p <= p + PW'(1);
    end
  end

  // Blink phase flips once every BLINK_FRAMES frame boundaries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (fb) begin
      if (fcnt == F_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Load capture: a load on the boundary bypasses pending and lands directly
  // in the display register; otherwise it waits in pending (last load wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blink <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
      pend_vld   <= 1'b0;
    end else if (load && fb) begin
      disp_val   <= value;
      disp_dp    <= dp_in;
      disp_blink <= blink_mask;
      pend_vld   <= 1'b0;
    end else if (load) begin
      pend_val   <= value;
      pend_dp    <= dp_in;
      pend_blink <= blink_mask;
      pend_vld   <= 1'b1;
    end else if (fb && pend_vld) begin
      disp_val   <= pend_val;
      disp_dp    <= pend_dp;
      disp_blink <= pend_blink;
      pend_vld   <= 1'b0;
    end
  end

  // Blank decision per digit: leading zeros (scanning down from the MSD,
  // never digit 0) and blink-off phase for masked digits.
  always_comb begin
    zf         = 1'b1;
    lane_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zf            = zf & (disp_val[i] == 4'h0);
      lane_blank[i] = (blank_lz && (i != 0) && zf) || (phase && disp_blink[i]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
      seg_digit_lane u_lane (
        .nib   (disp_val[g]),
        .dp    (disp_dp[g]),
        .blank (lane_blank[g]),
        .seg   (lane_seg[g]),
        .dp_o  (lane_dp[g])
      );
    end
  endgenerate

  // Select the current lane; digit enable is dropped in slot cycle 0 so the
  // segment lines settle before the next digit lights (anti-ghosting).
  always_comb begin
    nxt_sel = '0;
    if (p != '0) nxt_sel[d] = 1'b1;
    nxt_seg = lane_seg[d];
    nxt_dp  = lane_dp[d];
  end

  // Registered outputs with polarity applied; reset drives everything inactive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg         <= {7{SEG_INV}};
      dp_out      <= SEG_INV;
      digit_sel   <= {NUM_DIGITS{DIG_INV}};
      frame_start <= 1'b0;
    end else begin
      seg         <= nxt_seg ^ {7{SEG_INV}};
      dp_out      <= nxt_dp ^ SEG_INV;
      digit_sel   <= nxt_sel ^ {NUM_DIGITS{DIG_INV}};
      frame_start <= (p == '0) && (d == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-indexed behavioural model predicts every
// output cycle from elapsed time since reset and the load history; a few
// literal frames pin the model against hand-decoded segment patterns.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .dp_in(dp_in),
    .blink_mask(blink_mask), .blank_lz(blank_lz), .seg(seg), .dp_out(dp_out),
    .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] font [0:15];
  initial font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model state
  int         mt;
  logic [15:0] m_val, q_val;
  logic [3:0]  m_dp, q_dp, m_bl, q_bl;
  bit          m_pv;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fs;
  logic [3:0]  exp_sel;
  int          mp, md;
  bit          mblank, mbound;
  logic [6:0]  ms;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: time since reset gives slot and digit; blink phase is the number
  // of completed frames divided by BF, modulo 2.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_sel = 4'hF; exp_fs = 1'b0;
      mt = 0; m_val = '0; m_dp = '0; m_bl = '0;
      q_val = '0; q_dp = '0; q_bl = '0; m_pv = 1'b0;
    end else begin
      mp     = mt % SD;
      md     = (mt / SD) % ND;
      mblank = (blank_lz && md > 0 && (m_val >> (4 * md)) == 16'h0) ||
               ((((mt / FRAME) / BF) % 2 == 1) && m_bl[md]);
      ms      = mblank ? 7'h00 : font[m_val[4*md +: 4]];
      exp_seg = ~ms;
      exp_dp  = ~(mblank ? 1'b0 : m_dp[md]);
      exp_sel = ~((mp == 0) ? 4'h0 : 4'(1 << md));
      exp_fs  = (mp == 0 && md == 0);
      mbound  = (mt % FRAME) == FRAME - 1;
      if (load && mbound) begin
        m_val = value; m_dp = dp_in; m_bl = blink_mask; m_pv = 1'b0;
      end else if (load) begin
        q_val = value; q_dp = dp_in; q_bl = blink_mask; m_pv = 1'b1;
      end else if (mbound && m_pv) begin
        m_val = q_val; m_dp = q_dp; m_bl = q_bl; m_pv = 1'b0;
      end
      mt++;
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("seg", seg, exp_seg);
    chk("dp_out", 7'(dp_out), 7'(exp_dp));
    chk("digit_sel", 7'(digit_sel), 7'(exp_sel));
    chk("frame_start", 7'(frame_start), 7'(exp_fs));
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    @(negedge clk);
    value = v; dp_in = dp; blink_mask = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait (bounded) until frame_start is seen just after a rising edge.
  task automatic wait_fs(output bit ok);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!frame_start && n < 40);
    ok = frame_start;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_start_timeout: got none expected pulse within 40 cycles");
    end
  endtask

  // Literal check of one full frame's segment patterns.
  task automatic lit_frame(input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    bit ok;
    wait_fs(ok);
    if (ok) begin
      for (int i = 0; i < FRAME; i++) begin
        @(posedge clk); #1;
        case (digit_sel)
          4'b1110: chk("lit_d0", seg, e0);
          4'b1101: chk("lit_d1", seg, e1);
          4'b1011: chk("lit_d2", seg, e2);
          4'b0111: chk("lit_d3", seg, e3);
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_sel", 7'(digit_sel), 7'h0F);
    chk("rst_fs", 7'(frame_start), 7'h00);
    chk("rst_dp", 7'(dp_out), 7'h01);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("first_fs", 7'(frame_start), 7'h01);
    chk("first_sel", 7'(digit_sel), 7'h0F);
    @(posedge clk); #1;
    chk("second_sel", 7'(digit_sel), 7'h0E);
    chk("second_seg", seg, 7'b1000000);
    repeat (37) @(negedge clk);

    // mid-frame load
    do_load(16'h12AF, 4'b0000, 4'b0000);
    lit_frame(7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001);

    // two loads in one frame: last wins
    wait_fs(ok);
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h2222, 4'b0000, 4'b0000);
    lit_frame(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);

    // leading-zero blanking, live control
    do_load(16'h0050, 4'b0000, 4'b0000);
    @(negedge clk); blank_lz = 1'b1;
    lit_frame(7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111);
    @(negedge clk); blank_lz = 1'b0;
    lit_frame(7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000);

    // blink on digit 0, dp on digit 1
    do_load(16'h8888, 4'b0010, 4'b0001);
    repeat (5 * FRAME) @(negedge clk);

    // load exactly on the frame boundary
    wait_fs(ok);
    repeat (FRAME - 1) @(negedge clk);
    value = 16'hBEEF; dp_in = 4'b0000; blink_mask = 4'b0000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    lit_frame(7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011);
    repeat (2 * FRAME) @(negedge clk);

    // random traffic with a reset in the middle
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      load       = ($urandom_range(0, 7) == 0);
      value      = 16'($urandom);
      dp_in      = 4'($urandom);
      blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if (i == 400) begin
        load = 1'b0;
        #2 reset = 1'b1;
        #1 chk("async_rst_sel", 7'(digit_sel), 7'h0F);
        chk("async_rst_seg", seg, 7'h7F);
        @(negedge clk); #2 reset = 1'b0;
      end
    end
    @(negedge clk); load = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
